// File: rtl/mem_ctrl.sv
// Word-addressed RAM stage feeding the MDR: accepts one read or write at a time,
// inserts WAIT_STATES extra cycles, then pulses Done as the access completes.
module mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              Clear_n,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] MDataIn,
    output logic              Busy,
    output logic              Done
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                is_write;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                access;

    // The array access happens on the edge that leaves WAIT with the counter drained.
    assign access = (state == S_WAIT) && (wait_cnt == 4'd0);

    // NOTE: non-blocking assignments so every register here updates from pre-edge values.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            data_q   <= '0;
            is_write <= 1'b0;
            MDataIn  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Read || Write) begin
                        addr_q   <= Address;
                        data_q   <= DataIn;
                        is_write <= Write;
                        wait_cnt <= WS_LOAD;
                        Busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (!is_write) begin
                            MDataIn <= mem[addr_q];
                        end
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the array has no reset; an async reset forces IDLE, which blocks any pending write.
    always_ff @(posedge clk) begin
        if (access && is_write) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: instance 0 uses 2 wait states, instance 1 uses none.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [8:0]  addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        busy [2];
    logic        done [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: array contents, last read value, written addresses.
    logic [31:0] ref_mem  [2][512];
    logic [31:0] ref_dout [2];
    int          written  [2][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_ctrl #(
            .DATA_W     (32),
            .ADDR_W     (9),
            .WAIT_STATES(g == 0 ? 2 : 0)
        ) u_dut (
            .clk    (clk),
            .Clear_n(clear_n),
            .Read   (rd[g]),
            .Write  (wr[g]),
            .Address(addr[g]),
            .DataIn (din[g]),
            .MDataIn(dout[g]),
            .Busy   (busy[g]),
            .Done   (done[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Issue one command and check Busy/Done/MDataIn on every edge until it retires.
    task automatic do_cmd(input int k, input logic r, input logic w, input logic [8:0] a,
                          input logic [31:0] d, input bit mid_pulse);
        int          ws;
        logic [31:0] old_d;
        logic [31:0] new_d;
        logic        exp_b;
        logic        exp_d;
        logic [31:0] exp_q;
        ws    = ws_of(k);
        old_d = ref_dout[k];
        new_d = old_d;
        if (w) begin
            ref_mem[k][a] = d;
            written[k].push_back(int'(a));
        end else if (r) begin
            new_d = ref_mem[k][a];
        end
        @(negedge clk);
        rd[k] = r; wr[k] = w; addr[k] = a; din[k] = d;
        for (int j = 0; j <= ws + 2; j++) begin
            @(posedge clk); #1;
            if (j == 0) begin
                rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = a + 9'd1; din[k] = '0;
            end
            exp_b = (j <= ws + 1);
            exp_d = (j == ws + 1);
            exp_q = (j >= ws + 1) ? new_d : old_d;
            n_tests++;
            if (busy[k] !== exp_b) begin
                n_fail++;
                $display("FAIL cmd_busy k=%0d a=%h j=%0d got %b exp %b", k, a, j, busy[k], exp_b);
            end
            n_tests++;
            if (done[k] !== exp_d) begin
                n_fail++;
                $display("FAIL cmd_done k=%0d a=%h j=%0d got %b exp %b", k, a, j, done[k], exp_d);
            end
            n_tests++;
            if (dout[k] !== exp_q) begin
                n_fail++;
                $display("FAIL cmd_data k=%0d a=%h j=%0d got %h exp %h", k, a, j, dout[k], exp_q);
            end
            if (mid_pulse && j == 1) rd[k] = 1'b1;
            if (mid_pulse && j == 2) rd[k] = 1'b0;
        end
        ref_dout[k] = new_d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0; ref_dout[k] = '0;
        end
        clear_n = 1'b1;
        #2 clear_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dout[k] !== 32'h0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_async k=%0d got q=%h b=%b d=%b exp 0/0/0", k, dout[k], busy[k], done[k]);
            end
        end
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dout[k] !== 32'h0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_idle k=%0d got q=%h b=%b d=%b exp 0/0/0", k, dout[k], busy[k], done[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        do_cmd(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0);
        do_cmd(0, 1'b1, 1'b0, 9'h005, 32'h0, 1'b0);
    endtask

    task automatic test_input_stability();
        // do_cmd moves Address to a+1 and DataIn to 0 right after acceptance.
        do_cmd(0, 1'b1, 1'b0, 9'h005, 32'h0, 1'b0);
        do_cmd(0, 1'b0, 1'b1, 9'h006, 32'h12345678, 1'b0);
    endtask

    task automatic test_collision_busy();
        do_cmd(0, 1'b1, 1'b1, 9'h1FF, 32'hA5A5A5A5, 1'b0);
        do_cmd(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
            n_tests++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ignore got b=%b d=%b exp 0/0", busy[0], done[0]);
            end
        end
    endtask

    task automatic test_zero_wait();
        do_cmd(1, 1'b0, 1'b1, 9'h010, 32'h00000001, 1'b0);
        do_cmd(1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);
    endtask

    // Read held high through completion: ignored in DONE, re-accepted in the next IDLE.
    task automatic test_back_to_back();
        int   ws;
        logic exp_b;
        logic exp_d;
        ws = ws_of(0);
        ref_dout[0] = ref_mem[0][9'h005];
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 9'h005;
        for (int j = 0; j <= 2 * ws + 5; j++) begin
            @(posedge clk); #1;
            exp_b = (j <= ws + 1) || (j >= ws + 3 && j <= 2 * ws + 4);
            exp_d = (j == ws + 1) || (j == 2 * ws + 4);
            n_tests++;
            if (busy[0] !== exp_b || done[0] !== exp_d) begin
                n_fail++;
                $display("FAIL held_read j=%0d got b=%b d=%b exp %b/%b", j, busy[0], done[0], exp_b, exp_d);
            end
            if (j == ws + 3) rd[0] = 1'b0;
        end
        n_tests++;
        if (dout[0] !== ref_dout[0]) begin
            n_fail++;
            $display("FAIL held_read_data got %h exp %h", dout[0], ref_dout[0]);
        end
    endtask

    task automatic test_reset_mid_cmd(input logic w);
        @(negedge clk);
        rd[0] = ~w; wr[0] = w; addr[0] = 9'h1FF; din[0] = 32'h0BAD0BAD;
        @(posedge clk); #1;
        rd[0] = 1'b0; wr[0] = 1'b0;
        @(posedge clk); #2;
        clear_n = 1'b0;
        #1;
        ref_dout[0] = '0;
        ref_dout[1] = '0;
        n_tests++;
        if (dout[0] !== 32'h0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || dout[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid w=%b got q=%h b=%b d=%b q1=%h exp 0", w, dout[0], busy[0], done[0], dout[1]);
        end
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_tests++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet w=%b got b=%b d=%b exp 0/0", w, busy[0], done[0]);
            end
        end
        do_cmd(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        int          op;
        logic [8:0]  a;
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 30; i++) begin
                op = int'($urandom_range(0, 2));
                d  = $urandom;
                if (op == 1 && written[k].size() > 0) begin
                    a = 9'(written[k][$urandom_range(0, written[k].size() - 1)]);
                    do_cmd(k, 1'b1, 1'b0, a, d, (k == 0) && ($urandom_range(0, 1) == 1));
                end else begin
                    a = 9'($urandom_range(0, 511));
                    do_cmd(k, op == 2, 1'b1, a, d, 1'b0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_input_stability();
        test_collision_busy();
        test_zero_wait();
        test_back_to_back();
        test_reset_mid_cmd(1'b0);
        test_reset_mid_cmd(1'b1);
        do_cmd(1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
